dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the pipeline MEM stage (core) and a
//  host/debug requester (loader, test bench, DMA). Core has priority; a host kept
//  waiting for MAX_WAIT cycles forces a one-cycle core stall, which freezes the pipe.
//  Sits between the MEM-stage signals and dataMemory. core_stall is ANDed (inverted)
//  into the processor enable.
// PARAMETERS
//  ADDR_W    8   data-memory address width
//  DATA_W    32  data width
//  MAX_WAIT  8   blocked host cycles before a forced stall (legal range >= 1)
//  CNT_W     16  perf-counter width (only used with DMEM_ARB_PERF_EN)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous, active-high reset
//  core_rden    in   1       MEM-stage read request (memReadM)
//  core_wren    in   1       MEM-stage write request (memWriteM)
//  core_addr    in   ADDR_W  MEM-stage address
//  core_wdata   in   DATA_W  MEM-stage store data
//  core_rdata   out  DATA_W  load data to the MEM/WB pipe (= mem_q)
//  core_stall   out  1       registered; 1 = processor enable must be low this cycle
//  host_req     in   1       host access request; held stable until host_gnt
//  host_we      in   1       1 = write, 0 = read
//  host_addr    in   ADDR_W  host address
//  host_wdata   in   DATA_W  host write data
//  host_gnt     out  1       combinational; host access performed this cycle
//  host_rvalid  out  1       registered 1-cycle pulse; host_rdata valid
//  host_rdata   out  DATA_W  registered host read data
//  mem_addr     out  ADDR_W  to dataMemory address
//  mem_data     out  DATA_W  to dataMemory data
//  mem_rden     out  1       to dataMemory rden
//  mem_wren     out  1       to dataMemory wren
//  mem_q        in   DATA_W  dataMemory q; valid 1 cycle after mem_rden
//  perf_host_cnt  out CNT_W  host grants (macro only)
//  perf_stall_cnt out CNT_W  forced-stall cycles (macro only)
// BEHAVIOUR
//  - Reset: state S_CORE, core_stall=0, host_rvalid=0, host_rdata=0, wait_cnt=0,
//    perf counters=0. host_gnt=0 and mem_rden/mem_wren=0 while rst=1.
//  - FSM S_CORE: port owned by core. host_req && !core_rden && !core_wren -> host_gnt=1
//    same cycle, no stall. host_req && core busy -> wait_cnt++; when wait_cnt==MAX_WAIT-1
//    and core still busy -> next S_FORCE, wait_cnt<=0.
//  - S_FORCE (exactly 1 cycle): core_stall=1, host_gnt=1, port muxed to host, core
//    rden/wren masked (the frozen pipe re-presents its access next cycle) -> S_CORE.
//  - wait_cnt clears on any host_gnt or when host_req=0.
//  - Port mux: host_gnt ? host signals (mem_rden=!host_we, mem_wren=host_we) : core.
//  - Reads: host read granted in cycle t -> host_rvalid=1, host_rdata=mem_q in t+1.
//    A core read in t+1 is unaffected (its q arrives t+2). One access per cycle, so
//    same-address core/host collisions are impossible.
//  - Back-to-back host requests allowed; each needs its own grant.
//  - Reset mid-operation: pending host_rvalid dropped, S_FORCE aborted, stall deasserts
//    on the cycle after rst.
// CONFIGURATION
//  DMEM_ARB_PERF_EN defined: perf_host_cnt += 1 per host_gnt, perf_stall_cnt += 1 per
//  S_FORCE cycle, both saturate at all-ones, cleared by rst.
//  Undefined: no counter flops; both perf outputs tie to 0.
// STRUCTURE
//  Package dmem_arb_pkg: state enum {S_CORE, S_FORCE}, width localparams.
//  Sub-module dmem_arb_wait_timer: MAX_WAIT counter with clear/inc and a 'expire' flag.
// TESTING
//  1 Core idle, host read 0x10 (mem=0xDEADBEEF) -> host_gnt same cycle; next cycle
//    host_rvalid=1, host_rdata=0xDEADBEEF; core_stall stays 0.
//  2 Core loads every cycle, host write 0x20=0x1234, MAX_WAIT=8 -> 8 blocked cycles;
//    cycle 9 core_stall=1, host_gnt=1, mem_wren=1; core_stall=0 on cycle 10.
//  3 Core busy 3 cycles then idle, host_req held -> gnt on cycle 4, no stall, wait_cnt=0.
//  4 Host read 0x10 in t, core read 0x11 (=0x55) in t+1 -> host_rdata=0xDEADBEEF at t+1,
//    core_rdata=0x55 at t+2.
//  5 rst asserted during S_FORCE -> next cycle core_stall=0, host_rvalid=0, state S_CORE.
//  6 DMEM_ARB_PERF_EN, run test 2 -> perf_host_cnt=1, perf_stall_cnt=1; without the
//    macro both read 0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
// Optional perf counters in the top are enabled by defining DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        S_CORE  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_e;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 8;
    localparam int CNT_W_DEF    = 16;

    // The wait counter only ever holds 0 .. max_wait-1.
    function automatic int wait_cnt_width(input int max_wait);
        if (max_wait > 1) begin
            return $clog2(max_wait);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core MEM-stage, host requester and dataMemory signals around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              core_rden;
    logic              core_wren;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  core_rden, core_wren, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_q,
        output core_rdata, core_stall,
        output host_gnt, host_rvalid, host_rdata,
        output mem_addr, mem_data, mem_rden, mem_wren
    );

    modport master (
        output core_rden, core_wren, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_q,
        input  core_rdata, core_stall,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_addr, mem_data, mem_rden, mem_wren
    );

endinterface

// File: rtl/dmem_port_arbiter_wait_timer.sv
// Counts consecutive blocked host cycles; expire flags the last one before a forced stall.
module dmem_arb_wait_timer
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int                WAIT_W = wait_cnt_width(MAX_WAIT);
    localparam logic [WAIT_W-1:0] LAST   = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] cnt_r;

    // Clear has priority so a grant or a forced stall always restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {WAIT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {WAIT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + WAIT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == LAST);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core MEM stage has priority, a starved host forces a 1-cycle stall.
// Define DMEM_ARB_PERF_EN to build the saturating host-grant / forced-stall counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]    perf_host_cnt,
    output logic [CNT_W-1:0]    perf_stall_cnt
);
    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              core_busy_s;
    logic              expire_s;
    logic              wait_inc_s;
    logic              wait_clr_s;
    logic              host_gnt_s;
    logic              mem_rden_s;
    logic              mem_wren_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_data_s;
    logic              core_stall_r;
    logic              host_rvalid_r;
    logic [DATA_W-1:0] host_rdata_r;

    assign core_busy_s = bus.core_rden | bus.core_wren;

    dmem_arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr_s),
        .inc    (wait_inc_s),
        .expire (expire_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_CORE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: leave S_CORE only when the host has waited its full budget.
    always_comb begin
        state_nxt_s = S_CORE;
        case (state_r)
            S_CORE: begin
                if (bus.host_req && core_busy_s && expire_s) begin
                    state_nxt_s = S_FORCE;
                end else begin
                    state_nxt_s = S_CORE;
                end
            end
            S_FORCE: state_nxt_s = S_CORE;
            default: state_nxt_s = S_CORE;
        endcase
    end

    // Grant and wait-timer control; nothing is granted while in reset.
    always_comb begin
        host_gnt_s = 1'b0;
        wait_inc_s = 1'b0;
        wait_clr_s = 1'b1;
        if (rst) begin
            host_gnt_s = 1'b0;
            wait_inc_s = 1'b0;
            wait_clr_s = 1'b1;
        end else begin
            case (state_r)
                S_CORE: begin
                    host_gnt_s = bus.host_req & ~core_busy_s;
                    wait_inc_s = bus.host_req & core_busy_s;
                    wait_clr_s = ~(bus.host_req & core_busy_s) | expire_s;
                end
                S_FORCE: begin
                    host_gnt_s = bus.host_req;
                    wait_inc_s = 1'b0;
                    wait_clr_s = 1'b1;
                end
                default: begin
                    host_gnt_s = 1'b0;
                    wait_inc_s = 1'b0;
                    wait_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Port mux: core access is masked during the forced cycle; the frozen pipe retries it.
    always_comb begin
        mem_addr_s = bus.core_addr;
        mem_data_s = bus.core_wdata;
        mem_rden_s = 1'b0;
        mem_wren_s = 1'b0;
        if (host_gnt_s) begin
            mem_addr_s = bus.host_addr;
            mem_data_s = bus.host_wdata;
            mem_rden_s = ~bus.host_we;
            mem_wren_s = bus.host_we;
        end else if (rst || (state_r == S_FORCE)) begin
            mem_rden_s = 1'b0;
            mem_wren_s = 1'b0;
        end else begin
            mem_rden_s = bus.core_rden;
            mem_wren_s = bus.core_wren;
        end
    end

    // Registered stall and host read-valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_stall_r  <= 1'b0;
            host_rvalid_r <= 1'b0;
        end else begin
            core_stall_r  <= (state_nxt_s == S_FORCE);
            host_rvalid_r <= host_gnt_s & ~bus.host_we;
        end
    end

    // Hold the last host read word once the RAM output moves on to other accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rdata_r <= {DATA_W{1'b0}};
        end else if (host_rvalid_r) begin
            host_rdata_r <= bus.mem_q;
        end else begin
            host_rdata_r <= host_rdata_r;
        end
    end

    // mem_q is already a RAM register, so it is steered straight out in the valid cycle.
    assign bus.host_rdata  = host_rvalid_r ? bus.mem_q : host_rdata_r;
    assign bus.host_rvalid = host_rvalid_r;
    assign bus.host_gnt    = host_gnt_s;
    assign bus.core_stall  = core_stall_r;
    assign bus.core_rdata  = bus.mem_q;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_data    = mem_data_s;
    assign bus.mem_rden    = mem_rden_s;
    assign bus.mem_wren    = mem_wren_s;

`ifdef DMEM_ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] perf_host_r;
    logic [CNT_W-1:0] perf_stall_r;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_host_r  <= {CNT_W{1'b0}};
            perf_stall_r <= {CNT_W{1'b0}};
        end else begin
            if (host_gnt_s && (perf_host_r != CNT_MAX)) begin
                perf_host_r <= perf_host_r + CNT_W'(1);
            end else begin
                perf_host_r <= perf_host_r;
            end
            if ((state_r == S_FORCE) && (perf_stall_r != CNT_MAX)) begin
                perf_stall_r <= perf_stall_r + CNT_W'(1);
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_host_cnt  = perf_host_r;
    assign perf_stall_cnt = perf_stall_r;
`else
    assign perf_host_cnt  = {CNT_W{1'b0}};
    assign perf_stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: vector table plus hand sequences for stall/reset cases.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] perf_host_cnt;
    logic [15:0] perf_stall_cnt;
    int          checks;
    int          errors;

    dmem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_port_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .MAX_WAIT (8),
        .CNT_W    (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .perf_host_cnt  (perf_host_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data memory; preloaded while in reset.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            bus.mem_q     <= 32'h0;
            mem[8'h10]    <= 32'hDEADBEEF;
            mem[8'h11]    <= 32'h00000055;
        end else begin
            if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_data;
            if (bus.mem_rden) bus.mem_q <= mem[bus.mem_addr];
        end
    end

    typedef struct {
        logic        cr, cw;
        logic [7:0]  caddr;
        logic        hreq, hwe;
        logic [7:0]  haddr;
        logic [31:0] hwd;
        logic        gnt, mrd, mwr;
        logic [7:0]  maddr;
        logic        stall, rv;
        logic [31:0] rdata;
        logic        chk_crd;
        logic [31:0] crd;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic cr, input logic cw, input logic [7:0] caddr,
                                input logic hreq, input logic hwe, input logic [7:0] haddr,
                                input logic [31:0] hwd, input logic gnt, input logic mrd,
                                input logic mwr, input logic [7:0] maddr, input logic stall,
                                input logic rv, input logic [31:0] rdata,
                                input logic chk_crd, input logic [31:0] crd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.caddr = caddr; v.hreq = hreq; v.hwe = hwe;
        v.haddr = haddr; v.hwd = hwd; v.gnt = gnt; v.mrd = mrd; v.mwr = mwr;
        v.maddr = maddr; v.stall = stall; v.rv = rv; v.rdata = rdata;
        v.chk_crd = chk_crd; v.crd = crd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic cr, input logic cw, input logic [7:0] caddr,
                          input logic hreq, input logic hwe, input logic [7:0] haddr,
                          input logic [31:0] hwd);
        bus.core_rden  = cr;
        bus.core_wren  = cw;
        bus.core_addr  = caddr;
        bus.core_wdata = 32'h0;
        bus.host_req   = hreq;
        bus.host_we    = hwe;
        bus.host_addr  = haddr;
        bus.host_wdata = hwd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_ph;
    logic [15:0] exp_ps;

    initial begin
        checks = 0;
        errors = 0;
`ifdef DMEM_ARB_PERF_EN
        exp_ph = 16'd1;
        exp_ps = 16'd1;
`else
        exp_ph = 16'd0;
        exp_ps = 16'd0;
`endif
        vecs[0]  = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'h10,32'h0,  1'b1,1'b1,1'b0,8'h10, 1'b0,1'b0,32'h0,        1'b0,32'h0);
        vecs[1]  = mk(1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00,32'h0,  1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,32'hDEADBEEF, 1'b0,32'h0);
        vecs[2]  = mk(1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00,32'h0,  1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,32'hDEADBEEF, 1'b0,32'h0);
        vecs[3]  = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'h10,32'h0,  1'b1,1'b1,1'b0,8'h10, 1'b0,1'b0,32'hDEADBEEF, 1'b0,32'h0);
        vecs[4]  = mk(1'b1,1'b0,8'h11, 1'b0,1'b0,8'h00,32'h0,  1'b0,1'b1,1'b0,8'h11, 1'b0,1'b1,32'hDEADBEEF, 1'b0,32'h0);
        vecs[5]  = mk(1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00,32'h0,  1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,32'hDEADBEEF, 1'b1,32'h55);
        for (int k = 6; k < 14; k++) begin
            vecs[k] = mk(1'b1,1'b0,8'h11, 1'b1,1'b1,8'h20,32'h1234, 1'b0,1'b1,1'b0,8'h11, 1'b0,1'b0,32'hDEADBEEF, 1'b0,32'h0);
        end
        vecs[14] = mk(1'b1,1'b0,8'h11, 1'b1,1'b1,8'h20,32'h1234, 1'b1,1'b0,1'b1,8'h20, 1'b1,1'b0,32'hDEADBEEF, 1'b0,32'h0);
        vecs[15] = mk(1'b1,1'b0,8'h11, 1'b0,1'b0,8'h00,32'h0,  1'b0,1'b1,1'b0,8'h11, 1'b0,1'b0,32'hDEADBEEF, 1'b0,32'h0);
        vecs[16] = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'h20,32'h0,  1'b1,1'b1,1'b0,8'h20, 1'b0,1'b0,32'hDEADBEEF, 1'b0,32'h0);
        vecs[17] = mk(1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00,32'h0,  1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,32'h00001234, 1'b0,32'h0);

        // Reset with both requesters active: nothing may reach the memory.
        rst = 1'b1;
        set_in(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h10, 32'h0);
        repeat (3) @(posedge clk);
        #4;
        chk("rst host_gnt", 32'(bus.host_gnt), 32'h0);
        chk("rst mem_rden", 32'(bus.mem_rden), 32'h0);
        chk("rst mem_wren", 32'(bus.mem_wren), 32'h0);
        chk("rst core_stall", 32'(bus.core_stall), 32'h0);
        chk("rst host_rvalid", 32'(bus.host_rvalid), 32'h0);
        chk("rst host_rdata", bus.host_rdata, 32'h0);
        chk("rst perf_host", 32'(perf_host_cnt), 32'h0);
        chk("rst perf_stall", 32'(perf_stall_cnt), 32'h0);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);

        // Table: idle-core host read, host/core read ordering, 8-cycle starvation then forced write.
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            set_in(vecs[i].cr, vecs[i].cw, vecs[i].caddr, vecs[i].hreq, vecs[i].hwe,
                   vecs[i].haddr, vecs[i].hwd);
            #3;
            chk($sformatf("v%0d host_gnt", i), 32'(bus.host_gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d mem_rden", i), 32'(bus.mem_rden), 32'(vecs[i].mrd));
            chk($sformatf("v%0d mem_wren", i), 32'(bus.mem_wren), 32'(vecs[i].mwr));
            chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].maddr));
            chk($sformatf("v%0d core_stall", i), 32'(bus.core_stall), 32'(vecs[i].stall));
            chk($sformatf("v%0d host_rvalid", i), 32'(bus.host_rvalid), 32'(vecs[i].rv));
            chk($sformatf("v%0d host_rdata", i), bus.host_rdata, vecs[i].rdata);
            if (vecs[i].gnt && vecs[i].mwr) chk($sformatf("v%0d mem_data", i), bus.mem_data, vecs[i].hwd);
            if (vecs[i].chk_crd) chk($sformatf("v%0d core_rdata", i), bus.core_rdata, vecs[i].crd);
        end

        // Core busy 3 cycles then idle: grant on the 4th cycle without a stall.
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            set_in(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h10, 32'h0);
            #3;
            chk($sformatf("t3 busy%0d host_gnt", c), 32'(bus.host_gnt), 32'h0);
        end
        next_cycle();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 32'h0);
        #3;
        chk("t3 idle host_gnt", 32'(bus.host_gnt), 32'h1);
        chk("t3 idle core_stall", 32'(bus.core_stall), 32'h0);

        // Back-to-back request: the wait count restarted, so a full 8 blocked cycles again.
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            set_in(1'b0, 1'b1, 8'h30, 1'b1, 1'b1, 8'h21, 32'h77);
            #3;
            chk($sformatf("b2b blk%0d host_gnt", c), 32'(bus.host_gnt), 32'h0);
            chk($sformatf("b2b blk%0d core_stall", c), 32'(bus.core_stall), 32'h0);
            if (c == 0) chk("b2b host_rdata", bus.host_rdata, 32'hDEADBEEF);
        end
        next_cycle();
        #3;
        chk("b2b force host_gnt", 32'(bus.host_gnt), 32'h1);
        chk("b2b force core_stall", 32'(bus.core_stall), 32'h1);
        chk("b2b force mem_addr", 32'(bus.mem_addr), 32'h21);
        chk("b2b force mem_data", bus.mem_data, 32'h77);
        next_cycle();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        #3;
        chk("b2b after core_stall", 32'(bus.core_stall), 32'h0);

        // Reset asserted inside the forced cycle.
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            set_in(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h10, 32'h0);
        end
        next_cycle();
        #3;
        chk("t5 force core_stall", 32'(bus.core_stall), 32'h1);
        rst = 1'b1;
        #1;
        chk("t5 rst host_gnt", 32'(bus.host_gnt), 32'h0);
        chk("t5 rst mem_rden", 32'(bus.mem_rden), 32'h0);
        next_cycle();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        #3;
        chk("t5 after core_stall", 32'(bus.core_stall), 32'h0);
        chk("t5 after host_rvalid", 32'(bus.host_rvalid), 32'h0);
        chk("t5 after perf_host", 32'(perf_host_cnt), 32'h0);

        // Starved host write after reset: one grant, one forced-stall cycle.
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            set_in(1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h20, 32'h1234);
        end
        next_cycle();
        #3;
        chk("t6 force core_stall", 32'(bus.core_stall), 32'h1);
        chk("t6 force mem_wren", 32'(bus.mem_wren), 32'h1);
        next_cycle();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        #3;
        chk("t6 core_stall", 32'(bus.core_stall), 32'h0);
        chk("t6 perf_host", 32'(perf_host_cnt), 32'(exp_ph));
        chk("t6 perf_stall", 32'(perf_stall_cnt), 32'(exp_ps));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
